// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory LSU: access-size codes and FSM states.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    PRESET = 2'd1,
    READY  = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/data_memory_lsu_if.sv
// Load/store bus between the CPU datapath and the data memory.
interface data_memory_lsu_if;

  logic        WE;
  logic        RE;
  logic [2:0]  size;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        busy;
  logic        misalign;
  logic        oor;
  logic        bad_size;
  logic        fault;

  modport master (
    output WE, RE, size, A, WD,
    input  RD, busy, misalign, oor, bad_size, fault
  );

  modport slave (
    input  WE, RE, size, A, WD,
    output RD, busy, misalign, oor, bad_size, fault
  );

endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a word and sign- or zero-extends it.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[7:0];
    h    = lane[1] ? word[31:16] : word[15:0];
    data = '0;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    case (size)
      SZ_B:    data = {{24{b[7]}}, b};
      SZ_BU:   data = {24'h0, b};
      SZ_H:    data = {{16{h[15]}}, h};
      SZ_HU:   data = {16'h0, h};
      SZ_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory with sub-word load/store, access checking,
// sticky fault flag and a post-reset clear/preset sequence.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned PRESET_ADDR = 30,
  parameter logic [31:0] PRESET_DATA = 32'h0000_0020
) (
  input  logic             clk,
  input  logic             rst,
  data_memory_lsu_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BYTES = 4 * DEPTH;

  dmem_state_t       state, state_n;
  logic [AW-1:0]     cnt;
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     idx;
  logic [1:0]        lane;
  logic              err;
  logic              store_en;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       ext;
  logic              fault_q;

  assign idx  = bus.A[AW+1:2];
  assign lane = bus.A[1:0];

  // Access checks are purely combinational so the CPU sees them in-cycle.
  assign bus.misalign = (((bus.size == SZ_H) || (bus.size == SZ_HU)) && bus.A[0])
                      || ((bus.size == SZ_W) && (bus.A[1:0] != 2'b00));
  assign bus.oor      = (bus.A >= 32'(BYTES));
  assign bus.bad_size = (bus.size == 3'b011) || (bus.size == 3'b110) || (bus.size == 3'b111)
                      || (bus.WE && ((bus.size == SZ_BU) || (bus.size == SZ_HU)));
  assign err          = bus.misalign | bus.oor | bus.bad_size;

  assign bus.busy  = (state != READY);
  assign bus.fault = fault_q;
  assign store_en  = (state == READY) && bus.WE && !err;

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      CLEAR:   if (cnt == AW'(DEPTH - 1)) state_n = PRESET;
      PRESET:  state_n = READY;
      READY:   state_n = READY;
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + AW'(1);
  end

  // Byte-lane enables and replicated store data.
  always_comb begin
    be    = 4'b0000;
    wlane = bus.WD;
    case (bus.size)
      SZ_B: begin
        be    = 4'b0001 << lane;
        wlane = {4{bus.WD[7:0]}};
      end
      SZ_H: begin
        be    = bus.A[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.WD[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!store_en) be = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        CLEAR:  mem[cnt] <= '0;
        PRESET: mem[AW'(PRESET_ADDR)] <= PRESET_DATA;
        READY: begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                             fault_q <= 1'b0;
    else if ((state == READY) && (bus.WE | bus.RE) && err) fault_q <= 1'b1;
  end

  load_extend u_load_extend (
    .word (mem[idx]),
    .lane (lane),
    .size (bus.size),
    .data (ext)
  );

  assign bus.RD = (bus.busy || err) ? 32'h0 : ext;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed self-checking bench for data_memory_lsu (small and default configs).
module tb_data_memory_lsu;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  data_memory_lsu_if bus ();
  data_memory_lsu_if bus_def ();

  data_memory_lsu #(.DEPTH(16), .PRESET_ADDR(5), .PRESET_DATA(32'hCAFEBABE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  data_memory_lsu dut_def (
    .clk (clk),
    .rst (rst),
    .bus (bus_def.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.WE = 1'b0; bus.RE = 1'b0; bus.size = SZ_W; bus.A = 32'h0; bus.WD = 32'h0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    bus.A = a; bus.WD = d; bus.size = sz; bus.WE = 1'b1;
    step();
    bus.WE = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] sz);
    bus.A = a; bus.size = sz; bus.WE = 1'b0;
    #1;
  endtask

  task automatic reset_and_wait();
    int e;
    rst = 1'b1; idle();
    repeat (2) step();
    rst = 1'b0;
    e = 0;
    while (bus.busy && e < 100) begin step(); e++; end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_wait: busy=%b after %0d edges, required 0", bus.busy, e);
    end
  endtask

  task automatic test_reset();
    int edges, rd_bad;
    logic [31:0] exp;
    rst = 1'b1; idle(); bus.A = 32'h14;
    repeat (2) step();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", bus.fault); end
    n_cmp++; if (bus.RD !== 32'h0) begin n_bad++; $display("FAIL rst_rd: got %h want 0", bus.RD); end
    rst = 1'b0;
    edges = 0; rd_bad = 0;
    while (edges < 100) begin
      step(); edges++;
      if (bus.busy !== 1'b1) break;
      if (bus.RD !== 32'h0) rd_bad++;
    end
    n_cmp++; if (edges != 17) begin n_bad++; $display("FAIL busy_edges: got %0d want 17", edges); end
    n_cmp++; if (rd_bad != 0) begin n_bad++; $display("FAIL busy_rd: %0d nonzero RD cycles, want 0", rd_bad); end
    for (int i = 0; i < 16; i++) begin
      load(32'(i * 4), SZ_W);
      exp = (i == 5) ? 32'hCAFEBABE : 32'h0;
      n_cmp++;
      if (bus.RD !== exp) begin n_bad++; $display("FAIL clear_word%0d: got %h want %h", i, bus.RD, exp); end
    end
  endtask

  task automatic test_default_preset();
    int e;
    e = 0;
    while (bus_def.busy && e < 3000) begin step(); e++; end
    #1;
    n_cmp++;
    if (bus_def.RD !== 32'h0000_0020) begin
      n_bad++; $display("FAIL default_preset: got %h want 00000020", bus_def.RD);
    end
  endtask

  task automatic test_subword();
    store(32'h20, 32'h11223344, SZ_W);
    store(32'h21, 32'h000000AA, SZ_B);
    store(32'h22, 32'h0000BEEF, SZ_H);
    load(32'h20, SZ_W);
    n_cmp++; if (bus.RD !== 32'hBEEFAA44) begin n_bad++; $display("FAIL lw20: got %h want beefaa44", bus.RD); end
    load(32'h21, SZ_B);
    n_cmp++; if (bus.RD !== 32'hFFFFFFAA) begin n_bad++; $display("FAIL lb21: got %h want ffffffaa", bus.RD); end
    load(32'h21, SZ_BU);
    n_cmp++; if (bus.RD !== 32'h000000AA) begin n_bad++; $display("FAIL lbu21: got %h want 000000aa", bus.RD); end
    load(32'h22, SZ_H);
    n_cmp++; if (bus.RD !== 32'hFFFFBEEF) begin n_bad++; $display("FAIL lh22: got %h want ffffbeef", bus.RD); end
    load(32'h22, SZ_HU);
    n_cmp++; if (bus.RD !== 32'h0000BEEF) begin n_bad++; $display("FAIL lhu22: got %h want 0000beef", bus.RD); end
    load(32'h20, SZ_BU);
    n_cmp++; if (bus.RD !== 32'h00000044) begin n_bad++; $display("FAIL lbu20: got %h want 00000044", bus.RD); end
  endtask

  task automatic test_store_latency();
    bus.A = 32'h20; bus.size = SZ_W; bus.WD = 32'h00000055; bus.WE = 1'b1;
    #1;
    n_cmp++; if (bus.RD !== 32'hBEEFAA44) begin n_bad++; $display("FAIL same_cycle_old: got %h want beefaa44", bus.RD); end
    step();
    bus.WE = 1'b0;
    #1;
    n_cmp++; if (bus.RD !== 32'h00000055) begin n_bad++; $display("FAIL store_visible: got %h want 00000055", bus.RD); end
  endtask

  task automatic test_misalign();
    bus.A = 32'h01; bus.size = SZ_W; bus.WD = 32'h12345678; bus.WE = 1'b1;
    #1;
    n_cmp++; if (bus.misalign !== 1'b1) begin n_bad++; $display("FAIL misalign_sw: got %b want 1", bus.misalign); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL fault_pre: got %b want 0", bus.fault); end
    step();
    bus.WE = 1'b0;
    n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL fault_misalign: got %b want 1", bus.fault); end
    load(32'h00, SZ_W);
    n_cmp++; if (bus.RD !== 32'h0) begin n_bad++; $display("FAIL word0_kept: got %h want 0", bus.RD); end
    bus.RE = 1'b1;
    load(32'h03, SZ_H);
    n_cmp++; if (bus.RD !== 32'h0) begin n_bad++; $display("FAIL lh03_rd: got %h want 0", bus.RD); end
    n_cmp++; if (bus.misalign !== 1'b1) begin n_bad++; $display("FAIL lh03_mis: got %b want 1", bus.misalign); end
    load(32'h02, SZ_H);
    n_cmp++; if (bus.misalign !== 1'b0) begin n_bad++; $display("FAIL lh02_mis: got %b want 0", bus.misalign); end
    bus.RE = 1'b0;
    repeat (3) step();
    n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky: got %b want 1", bus.fault); end
  endtask

  task automatic test_range_size();
    reset_and_wait();
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL fault_cleared: got %b want 0", bus.fault); end
    load(32'h3C, SZ_W);
    n_cmp++; if (bus.oor !== 1'b0) begin n_bad++; $display("FAIL oor_3c: got %b want 0", bus.oor); end
    bus.RE = 1'b1;
    load(32'h40, SZ_W);
    n_cmp++; if (bus.oor !== 1'b1) begin n_bad++; $display("FAIL oor_40: got %b want 1", bus.oor); end
    n_cmp++; if (bus.RD !== 32'h0) begin n_bad++; $display("FAIL oor_rd: got %h want 0", bus.RD); end
    step();
    bus.RE = 1'b0;
    n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL fault_oor: got %b want 1", bus.fault); end

    reset_and_wait();
    load(32'h08, SZ_BU);
    n_cmp++; if (bus.bad_size !== 1'b0) begin n_bad++; $display("FAIL bad_size_lbu: got %b want 0", bus.bad_size); end
    bus.WD = 32'hFFFFFFFF; bus.WE = 1'b1;
    #1;
    n_cmp++; if (bus.bad_size !== 1'b1) begin n_bad++; $display("FAIL bad_size_sbu: got %b want 1", bus.bad_size); end
    step();
    bus.WE = 1'b0;
    n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL fault_bad_size: got %b want 1", bus.fault); end
    load(32'h08, SZ_W);
    n_cmp++; if (bus.RD !== 32'h0) begin n_bad++; $display("FAIL word2_kept: got %h want 0", bus.RD); end
  endtask

  task automatic test_busy_suppress();
    int e;
    rst = 1'b1; idle();
    repeat (2) step();
    rst = 1'b0;
    bus.A = 32'h00; bus.size = SZ_W; bus.WD = 32'hFFFFFFFF; bus.WE = 1'b1;
    e = 0;
    while (bus.busy && e < 100) begin step(); e++; end
    bus.WE = 1'b0;
    n_cmp++; if (e != 17) begin n_bad++; $display("FAIL suppress_edges: got %0d want 17", e); end
    load(32'h00, SZ_W);
    n_cmp++; if (bus.RD !== 32'h0) begin n_bad++; $display("FAIL busy_store: got %h want 0", bus.RD); end
  endtask

  task automatic test_reset_mid_clear();
    int e;
    store(32'h10, 32'h0BADF00D, SZ_W);
    bus.RE = 1'b1;
    load(32'h02, SZ_W);
    step();
    bus.RE = 1'b0;
    rst = 1'b1; idle();
    step();
    rst = 1'b0;
    repeat (7) step();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midclear_busy: got %b want 1", bus.busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = 0;
    while (e < 100) begin
      step(); e++;
      if (bus.busy !== 1'b1) break;
    end
    n_cmp++; if (e != 17) begin n_bad++; $display("FAIL midclear_edges: got %0d want 17", e); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL midclear_fault: got %b want 0", bus.fault); end
    load(32'h10, SZ_W);
    n_cmp++; if (bus.RD !== 32'h0) begin n_bad++; $display("FAIL midclear_zeroed: got %h want 0", bus.RD); end
    load(32'h14, SZ_W);
    n_cmp++; if (bus.RD !== 32'hCAFEBABE) begin n_bad++; $display("FAIL midclear_preset: got %h want cafebabe", bus.RD); end
  endtask

  initial begin
    bus_def.WE = 1'b0; bus_def.RE = 1'b0; bus_def.size = SZ_W;
    bus_def.A = 32'h78; bus_def.WD = 32'h0;
    idle();
    test_reset();
    test_default_preset();
    test_subword();
    test_store_latency();
    test_misalign();
    test_range_size();
    test_busy_suppress();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
# data_memory_lsu

Parametrised, byte-addressable data memory for the single-cycle CPU, between the ALU address output and the register-file write-back mux. It adds RISC-V-style sub-word loads and stores (byte/half/word, signed/unsigned) and alignment and range checking with a sticky fault flag. After every reset it runs a clear sequence that zeroes the array and writes one preset word.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥ 4.
- `PRESET_ADDR`, 30: word index written with `PRESET_DATA` at the end of the clear sequence; must be < `DEPTH`.
- `PRESET_DATA`, 32'h00000020: preset word value.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `WE`  in  1  store enable.
- `RE`  in  1  load enable; only qualifies fault capture, since read data is always driven.
- `size`  in  3  access type (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `A`  in  32  byte address from the ALU.
- `WD`  in  32  store data; low byte/half used for B/H.
- `RD`  out  32  load data, extended per `size`.
- `busy`  out  1  clear sequence in progress.
- `misalign`  out  1  combinational: H/HU with A[0]=1, or W with A[1:0]≠0.
- `oor`  out  1  combinational: A ≥ 4·DEPTH.
- `bad_size`  out  1  combinational: size ∈ {011,110,111}, or WE=1 with size ∈ {100,101}.
- `fault`  out  1  sticky error flag.

## Operation
- FSM states: CLEAR, PRESET, READY.
- Word index is `A[$clog2(DEPTH)+1:2]`; byte lane is `A[1:0]`.
- `err` = `misalign | oor | bad_size`.
- **Rst=1 at an edge:** state ← CLEAR, cnt ← 0, fault ← 0. No array write occurs while rst is high.
- **CLEAR, rst=0:**
  - mem[cnt] ← 0 and cnt ← cnt+1.
  - At cnt = DEPTH−1, go to PRESET.
- **PRESET:** mem[PRESET_ADDR] ← PRESET_DATA, then go to READY.
- **READY, store:** WE=1 and err=0.
  - B: lane A[1:0] ← WD[7:0].
  - H: bytes {A[1],1},{A[1],0} ← WD[15:0].
  - W: full word ← WD.
  - Other bytes of the word are unchanged.
- **READY, load data:**
  - B/BU return the addressed byte, sign- or zero-extended.
  - H/HU return the addressed half, sign- or zero-extended.
  - W returns the full word.
  - RD is independent of RE.
- **Suppression:**
  - err=1: RD=0 and any store is suppressed.
  - busy=1: RD=0 and stores are ignored.
- **fault:** set at an edge in READY when (WE|RE)=1 and err=1. Cleared only by reset.

## Timing
- Reset values: busy=1, fault=0, RD=0. misalign/oor/bad_size follow their inputs in all states.
- After the last rst-high edge, busy stays 1 for exactly DEPTH+1 edges (DEPTH CLEAR edges, then one PRESET edge).
- busy drops after the PRESET edge. The first accepted store is at the following edge.
- Load latency is 0: combinational from A, size and array contents.
- Store latency is one edge; the new data is visible on RD in the cycle after that edge.
- Same-address store and load in one cycle: RD shows the old data until the edge.
- Rst during CLEAR or PRESET restarts the sequence at cnt=0. Rst in READY zeroes all contents via a new clear.
- Simultaneous WE and RE is legal; fault sets once and stays set.

## Structure
- Package `dmem_pkg` holds:
  - the size encodings as localparams (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU);
  - the state enum `dmem_state_t` {CLEAR, PRESET, READY}.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension. Inputs are word, A[1:0] and size; output is 32 bits.
- Top level holds the array, store byte-lane write logic, FSM/counter, error decode and fault register.

## Test plan
All scenarios use DEPTH=16, PRESET_ADDR=5, PRESET_DATA=32'hCAFEBABE unless stated.
- **Reset/clear:** hold rst 2 cycles, release, then count edges with busy=1.
  - Requires exactly 17 busy edges and RD=0 throughout.
  - Afterwards: LW at A=0x14 → RD=32'hCAFEBABE; LW at every other word → 0.
  - Default parameters: LW at A=0x78 → 32'h00000020.
- **Byte/half stores:** SW 0x11223344 @0x20; SB WD=0xAA @0x21; SH WD=0xBEEF @0x22.
  - Requires LW @0x20 → 0xBEEFAA44.
  - LB @0x21 → 0xFFFFFFAA; LBU @0x21 → 0x000000AA.
  - LH @0x22 → 0xFFFFBEEF; LHU @0x22 → 0x0000BEEF.
- **Misalign:** SW 0x12345678 @0x01.
  - Requires misalign=1, word 0 unchanged (still 0), fault=1 at the next edge and held until rst.
  - LH @0x03 → RD=0.
- **Range and illegal size:**
  - LW @0x40 → oor=1, RD=0.
  - Store with size=100 @0x08 → bad_size=1, word 2 unchanged.
  - Both cases set fault.
- **Busy suppression:** SW 0xFFFFFFFF @0x00 issued during CLEAR → after busy falls, LW @0x00 → 0.
- **Reset mid-clear:** assert rst at cnt=7 for 1 cycle → busy again lasts 17 edges, and fault is cleared.
